// File: rtl/mem_bridge_pkg.sv
// Shared constants and types for the memory-stage bridge: exception codes,
// access-size encodings, address regions and the device FSM states.
package mem_bridge_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DM,
        REG_DEV
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_bridge_decode.sv
// Combinational M-stage decode: region lookup, AdEL/AdES detection,
// byte-enable generation and store-data replication.
module mem_bridge_decode
    import mem_bridge_pkg::*;
#(
    parameter int          NUM_DEV    = 2,
    parameter logic [31:0] DEV_BASE   = 32'h7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] DEV_SPAN   = 32'd12,
    parameter logic [31:0] DM_LIMIT   = 32'h3000
) (
    input  logic               i_load,
    input  logic               i_store,
    input  logic [1:0]         i_size,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  logic [4:0]         i_exc_in,
    output logic               o_is_dm,
    output logic               o_is_dev,
    output logic [NUM_DEV-1:0] o_dev_hit,
    output logic [4:0]         o_exc,
    output logic [3:0]         o_byteen,
    output logic [31:0]        o_wdata
);

    logic [NUM_DEV-1:0] w_hit;
    logic [31:0]        w_lo;
    logic               w_ro;
    logic               w_mis;
    logic [4:0]         w_code;
    region_t            w_region;

    // Lowest-numbered window wins if windows were ever configured to overlap.
    always_comb begin
        w_hit = '0;
        w_lo  = '0;
        w_ro  = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_lo = DEV_BASE + 32'(i) * DEV_STRIDE;
            if (w_hit == '0 && i_addr >= w_lo && i_addr < w_lo + DEV_SPAN) begin
                w_hit[i] = 1'b1;
                w_ro     = (i_addr - w_lo) >= 32'd8;
            end
        end
    end

    always_comb begin
        w_region = REG_NONE;
        if (i_addr < DM_LIMIT)
            w_region = REG_DM;
        else if (|w_hit)
            w_region = REG_DEV;
    end

    assign o_is_dm   = (w_region == REG_DM);
    assign o_is_dev  = (w_region == REG_DEV);
    assign o_dev_hit = o_is_dev ? w_hit : '0;

    assign w_code = i_store ? EXC_ADES : EXC_ADEL;
    assign w_mis  = (i_size == SIZE_HALF && i_addr[0]) ||
                    (i_size == SIZE_WORD && i_addr[1:0] != 2'b00);

    always_comb begin
        o_exc = EXC_NONE;
        if (i_exc_in != EXC_NONE)
            o_exc = i_exc_in;
        else if (i_load || i_store) begin
            if (w_mis)
                o_exc = w_code;
            else if (w_region == REG_NONE)
                o_exc = w_code;
            else if (o_is_dev && i_size != SIZE_WORD)
                o_exc = w_code;
            else if (o_is_dev && i_store && w_ro)
                o_exc = w_code;
        end
    end

    always_comb begin
        case (i_size)
            SIZE_BYTE: begin
                o_byteen = 4'b0001 << i_addr[1:0];
                o_wdata  = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_byteen = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata  = {2{i_wdata[15:0]}};
            end
            default: begin
                o_byteen = 4'b1111;
                o_wdata  = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bridge_mc.sv
// Multi-cycle memory-stage bridge: combinational DM path plus a stalling
// valid/ready device FSM. MEM_BRIDGE_TIMEOUT_EN adds a DBE timeout in WAIT.
module mem_bridge_mc
    import mem_bridge_pkg::*;
#(
    parameter int          NUM_DEV    = 2,
    parameter logic [31:0] DEV_BASE   = 32'h7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] DEV_SPAN   = 32'd12,
    parameter logic [31:0] DM_LIMIT   = 32'h3000,
    parameter int          TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_m_load,
    input  logic                  i_m_store,
    input  logic [1:0]            i_m_size,
    input  logic [31:0]           i_m_addr,
    input  logic [31:0]           i_m_wdata,
    input  logic [4:0]            i_m_exc_in,
    input  logic                  i_flush,
    output logic [31:0]           o_dm_addr,
    output logic [3:0]            o_dm_byteen,
    output logic [31:0]           o_dm_wdata,
    input  logic [31:0]           i_dm_rdata,
    output logic [31:0]           o_dev_addr,
    output logic [31:0]           o_dev_wdata,
    output logic                  o_dev_we,
    output logic [NUM_DEV-1:0]    o_dev_valid,
    input  logic [NUM_DEV-1:0]    i_dev_ready,
    input  logic [32*NUM_DEV-1:0] i_dev_rdata,
    output logic                  o_stall,
    output logic [31:0]           o_rdata_raw,
    output logic [4:0]            o_exc_out
);

    logic               w_is_dm;
    logic               w_is_dev;
    logic [NUM_DEV-1:0] w_dev_hit;
    logic [4:0]         w_exc;
    logic [3:0]         w_byteen;
    logic [31:0]        w_wdata;
    logic               w_ok;
    logic               w_start;
    logic               w_ready;
    logic [31:0]        w_dev_rd;

    state_t             r_state;
    logic [NUM_DEV-1:0] r_dev_valid;
    logic [31:0]        r_dev_addr;
    logic [31:0]        r_dev_wdata;
    logic               r_dev_we;
    logic [31:0]        r_rd_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbe;
`endif

    mem_bridge_decode #(
        .NUM_DEV    (NUM_DEV),
        .DEV_BASE   (DEV_BASE),
        .DEV_STRIDE (DEV_STRIDE),
        .DEV_SPAN   (DEV_SPAN),
        .DM_LIMIT   (DM_LIMIT)
    ) u_decode (
        .i_load    (i_m_load),
        .i_store   (i_m_store),
        .i_size    (i_m_size),
        .i_addr    (i_m_addr),
        .i_wdata   (i_m_wdata),
        .i_exc_in  (i_m_exc_in),
        .o_is_dm   (w_is_dm),
        .o_is_dev  (w_is_dev),
        .o_dev_hit (w_dev_hit),
        .o_exc     (w_exc),
        .o_byteen  (w_byteen),
        .o_wdata   (w_wdata)
    );

    assign w_ok    = (i_m_load || i_m_store) && (w_exc == EXC_NONE) && !i_flush;
    assign w_start = (r_state == ST_IDLE) && w_ok && w_is_dev;

    assign o_dm_addr   = i_m_addr;
    assign o_dm_wdata  = w_wdata;
    assign o_dm_byteen = (i_m_store && w_ok && w_is_dm) ? w_byteen : 4'b0000;

    // r_dev_valid is one-hot while waiting, so it doubles as the ready/data select.
    assign w_ready = |(i_dev_ready & r_dev_valid);
    always_comb begin
        w_dev_rd = '0;
        for (int i = 0; i < NUM_DEV; i++)
            if (r_dev_valid[i])
                w_dev_rd = w_dev_rd | i_dev_rdata[32*i +: 32];
    end

    assign o_dev_valid = r_dev_valid;
    assign o_dev_addr  = r_dev_addr;
    assign o_dev_wdata = r_dev_wdata;
    assign o_dev_we    = r_dev_we;
    assign o_stall     = w_start || (r_state == ST_WAIT);

    always_comb begin
        o_rdata_raw = '0;
        o_exc_out   = EXC_NONE;
        case (r_state)
            ST_IDLE: begin
                o_exc_out = w_exc;
                if (i_m_load && w_exc == EXC_NONE && w_is_dm)
                    o_rdata_raw = i_dm_rdata;
            end
            ST_DONE: begin
                o_rdata_raw = r_rd_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                if (r_dbe)
                    o_exc_out = EXC_DBE;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_dev_valid <= '0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_dev_we    <= 1'b0;
            r_rd_q      <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_cnt       <= '0;
            r_dbe       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_dev_valid <= w_dev_hit;
                        r_dev_addr  <= i_m_addr;
                        r_dev_wdata <= w_wdata;
                        r_dev_we    <= i_m_store;
                        r_state     <= ST_WAIT;
                    end
                end
                // Flush is deliberately not looked at here: a started bus cycle finishes.
                ST_WAIT: begin
                    if (w_ready) begin
                        r_rd_q      <= w_dev_rd;
                        r_dev_valid <= '0;
                        r_dev_we    <= 1'b0;
                        r_state     <= ST_DONE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        r_cnt       <= '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rd_q      <= '0;
                        r_dev_valid <= '0;
                        r_dev_we    <= 1'b0;
                        r_dbe       <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    r_dbe   <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_bridge_mc.md
# mem_bridge_mc

Parametrised memory-stage access unit for the P7-class pipelined MIPS core. Decodes the M-stage address into the data memory or one of `NUM_DEV` peripheral windows, generates byte enables and replicated write data, and flags AdEL/AdES exceptions. Unlike the single-cycle bridge, peripherals are multi-cycle devices with a valid/ready handshake: the block stalls the pipeline until the device answers, with an optional timeout that raises a data bus error.

## Interface
Parameters:
- `NUM_DEV`, 2: number of peripheral windows (1..8).
- `DEV_BASE`, 32'h7f00: base address of device 0.
- `DEV_STRIDE`, 32'h10: address distance between consecutive device windows.
- `DEV_SPAN`, 12: bytes decoded per window; offsets 8..`DEV_SPAN`-1 are read-only.
- `DM_LIMIT`, 32'h3000: the data memory is `addr < DM_LIMIT`.
- `TIMEOUT`, 15: maximum wait cycles; used only with the macro.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `m_load` in 1: M-stage instruction is a load.
- `m_store` in 1: M-stage instruction is a store.
- `m_size` in 2: access size. 00 byte, 01 half, 10 word.
- `m_addr` in 32: effective address.
- `m_wdata` in 32: forwarded store data.
- `m_exc_in` in 5: exception code from earlier stages. 0 means none.
- `flush` in 1: CP0 interrupt/exception request; suppresses the access.
- `dm_addr` out 32; `dm_byteen` out 4; `dm_wdata` out 32; `dm_rdata` in 32.
- `dev_addr` out 32; `dev_wdata` out 32; `dev_we` out 1.
- `dev_valid` out `NUM_DEV`: one-hot request.
- `dev_ready` in `NUM_DEV`.
- `dev_rdata` in 32*`NUM_DEV`: flattened, device i at bits [32i+31:32i].
- `stall` out 1: freeze F/D/E/M.
- `rdata_raw` out 32: unextended load word, passed to the existing EXT.
- `exc_out` out 5: exception code forwarded to CP0.

## Operation
- Decode region: DM, device i, or none.
  - Device i hit: `DEV_BASE + i*DEV_STRIDE <= addr < DEV_BASE + i*DEV_STRIDE + DEV_SPAN`.
- Exception priority. Load reports 4, store reports 5:
  1. If `m_exc_in != 0`, pass it through and issue no access.
  2. Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  3. Region none.
  4. Non-word access to a device.
  5. Store to a read-only device offset.
- Byte enables:
  - byte: `1<<addr[1:0]`.
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Write data: replicated per size (byte ×4, half ×2, word as-is).
- `dm_byteen` is nonzero only for a store with no exception, region DM, and `!flush`.
- DM loads are combinational: `rdata_raw = dm_rdata` in the same cycle.
- Device FSM:
  - IDLE:
    - Transition: a device hit with no exception and `!flush` moves to WAIT.
    - `dev_valid[i]` is 1 from the WAIT-entry cycle.
    - `dev_we = m_store`.
    - `stall` is 1 combinationally in the hit cycle.
  - WAIT:
    - Hold `dev_valid`, `dev_addr`, `dev_wdata`, `dev_we` stable; `stall` = 1.
    - When `dev_ready[i]` = 1: latch `dev_rdata` slice i into `rd_q`, drop `dev_valid` next cycle, go to DONE.
    - `flush` is ignored in WAIT; the transaction always completes.
  - DONE:
    - `stall` = 0; `rdata_raw = rd_q`.
    - The pipeline advances at the end of this cycle; go to IDLE.
- Region none or an exception: no device or DM side effects, and `rdata_raw` = 0.

## Timing
- Reset values: state IDLE, `dev_valid` 0, `dev_we` 0, `rd_q` 0, timeout counter 0.
  - Combinational outputs follow their inputs.
- DM access: 0 extra cycles.
- Device access: the hit cycle, then ≥1 WAIT cycle, then the DONE cycle.
  - Minimum penalty is 2 stall cycles (ready in the first WAIT cycle).
- Ready asserted in the same cycle `dev_valid` rises is not possible; the handshake is sampled in WAIT only.
- Ready on a non-selected device is ignored.
- Reset mid-WAIT: IDLE on the next edge, `dev_valid` low, nothing latched.

## Configuration
- Macro: `MEM_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A counter increments each WAIT cycle.
  - When the counter equals `TIMEOUT` without ready: drop `dev_valid`, set `rd_q` = 0, go to DONE, and set `exc_out` = 7 (DBE) during DONE.
  - The counter clears on leaving WAIT.
- Undefined: there is no counter, and WAIT lasts until ready.

## Structure
- Package `mem_bridge_pkg` holds:
  - Exception constants: `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_DBE`=7.
  - Size encodings.
  - Region typedef.
  - FSM state enum.
- One sub-module, `mem_bridge_decode`: purely combinational region decode, exception check, and byte-enable generation.
- The FSM stays in the top level.

## Test plan
- Word store 0x12345678 to 0x1004 → `dm_byteen`=1111, `stall` 0, `exc_out` 0.
- Byte store 0xAB to 0x0003 → `dm_byteen`=1000, `dm_wdata`=0xABABABAB.
- Half load from 0x0001 → `exc_out`=4, `dm_byteen`=0.
- Word store to 0x7f08 → `exc_out`=5, no `dev_valid`.
- Word load from 0x7f14, `dev_ready[1]` raised after 3 WAIT cycles with data 0xCAFE0001 → `stall` high 4 cycles, then DONE with `rdata_raw`=0xCAFE0001.
- With `MEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT`=4, ready never raised → `dev_valid` drops after 4 WAIT cycles, DONE with `exc_out`=7, `rdata_raw`=0.
- `flush`=1 during a store to 0x7f00 in IDLE → no `dev_valid`, `stall` 0.
